// File: rtl/pc_sequencer.sv
// Purpose: fetch/execute sequencer driving instruction fetch, retirement and the PC write enable.
// Latency: 4 cycles fetch-to-fetch (REQ, WAIT, EXEC, UPDATE) with zero-wait memory and immediate exu_done.
// Backpressure: holds the request until ifu_req_ready; WAIT gives up after TIMEOUT cycles; EXEC waits on exu_done.
module pc_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    output logic [ADDR_W-1:0] ifu_req_addr,
    input  logic              ifu_rsp_valid,
    input  logic [31:0]       ifu_rsp_data,
    input  logic              ifu_rsp_err,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              exu_done,
    input  logic              halt_req,
    output logic              pc_wen,
    output logic [63:0]       retired,
    output logic              halted,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_UPDATE,
        S_HALT,
        S_ERROR
    } state_t;

    // Last WAIT cycle index: the counter starts at 0, so TIMEOUT cycles end at TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              req_hold;   // set after the first REQ cycle: addr_q now owns the address
    logic              rsp_ok;

    // A good response is only ever accepted while waiting for one.
    assign rsp_ok = (state == S_WAIT) && ifu_rsp_valid && !ifu_rsp_err;

    // The PC write from UPDATE lands on the edge entering REQ, so the first REQ
    // cycle forwards pc directly and registers it; later stalled cycles replay it.
    assign ifu_req_addr  = (state == S_REQ && !req_hold) ? pc : addr_q;
    assign ifu_req_valid = (state == S_REQ);
    assign pc_wen        = (state == S_UPDATE);
    assign halted        = (state == S_HALT);
    assign err           = (state == S_ERROR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a response beats the timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_REQ;
            S_REQ:    if (ifu_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (ifu_rsp_valid) begin
                    state_nxt = ifu_rsp_err ? S_ERROR : S_EXEC;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERROR;
                end
            end
            S_EXEC:   if (exu_done) state_nxt = halt_req ? S_HALT : S_UPDATE;
            S_UPDATE: state_nxt = S_REQ;
            S_HALT:   state_nxt = S_HALT;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Fetch address capture and hold while the request is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            req_hold <= 1'b0;
        end else begin
            if (state == S_REQ && !req_hold) begin
                addr_q <= pc;
            end
            req_hold <= (state == S_REQ) && !ifu_req_ready;
        end
    end

    // WAIT cycle counter: cleared while requesting, counts silent WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_REQ) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && !ifu_rsp_valid) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Instruction latch and its one-cycle "new" pulse on the first EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            if (rsp_ok) begin
                inst <= ifu_rsp_data;
            end
            inst_valid <= rsp_ok;
        end
    end

    // Retirement counter, one per UPDATE, wrapping naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (state == S_UPDATE) begin
            retired <= retired + 64'd1;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and fetch address.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles before a fetch error; legal range 1..65535.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port pc  input  ADDR_W  current value of the PC register.
REQ-006 Port ifu_req_valid  output  1  fetch request valid.
REQ-007 Port ifu_req_ready  input  1  memory accepts the request.
REQ-008 Port ifu_req_addr  output  ADDR_W  fetch address.
REQ-009 Port ifu_rsp_valid  input  1  fetch response valid.
REQ-010 Port ifu_rsp_data  input  32  fetched instruction.
REQ-011 Port ifu_rsp_err  input  1  fetch response error, qualified by ifu_rsp_valid.
REQ-012 Port inst  output  32  latched instruction for decode/execute.
REQ-013 Port inst_valid  output  1  one-cycle pulse: inst is new.
REQ-014 Port exu_done  input  1  execute stage finished the current instruction; PC datapath din/jump/branch controls are settled.
REQ-015 Port halt_req  input  1  current instruction is a halt (ebreak), qualified by exu_done.
REQ-016 Port pc_wen  output  1  write enable to the PC register.
REQ-017 Port retired  output  64  count of retired instructions.
REQ-018 Port halted  output  1  sequencer stopped by halt.
REQ-019 Port err  output  1  sequencer stopped by fetch error or timeout.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, EXEC, UPDATE, HALT and ERROR.
REQ-021 IDLE SHALL go to REQ unconditionally on the first clock edge after reset deasserts.
REQ-022 On entry to REQ, the block SHALL register pc into ifu_req_addr.
REQ-023 In REQ, ifu_req_valid SHALL be 1 and ifu_req_addr SHALL hold stable until ifu_req_ready=1.
REQ-024 REQ SHALL go to WAIT on the cycle where ifu_req_valid & ifu_req_ready.
REQ-025 ifu_rsp_valid SHALL be ignored outside WAIT; the earliest accepted response is the cycle after the request handshake.
REQ-026 In WAIT, rsp_valid & !rsp_err SHALL latch ifu_rsp_data into inst and go to EXEC.
REQ-027 In WAIT, rsp_valid & rsp_err SHALL go to ERROR; inst is unchanged.
REQ-028 The WAIT counter SHALL clear on WAIT entry and increment each WAIT cycle without a response.
REQ-029 When the WAIT counter reaches TIMEOUT, the FSM SHALL go to ERROR; a response arriving in that same cycle takes priority.
REQ-030 inst_valid SHALL be 1 only in the first EXEC cycle.
REQ-031 In EXEC, exu_done & !halt_req SHALL go to UPDATE.
REQ-032 In EXEC, exu_done & halt_req SHALL go to HALT without asserting pc_wen.
REQ-033 EXEC SHALL wait indefinitely while exu_done=0.
REQ-034 exu_done in a first EXEC cycle SHALL be honoured.
REQ-035 exu_done outside EXEC SHALL be ignored.
REQ-036 pc_wen SHALL be 1 only in UPDATE, exactly one cycle per instruction.
REQ-037 UPDATE SHALL go to REQ.
REQ-038 retired SHALL increment by 1 in each UPDATE cycle and wrap from 2^64-1 to 0.
REQ-039 HALT SHALL be terminal until reset, with halted=1.
REQ-040 ERROR SHALL be terminal until reset, with err=1.
REQ-041 In HALT and ERROR, ifu_req_valid and pc_wen SHALL stay 0.
REQ-042 With zero-wait memory and exu_done in the first EXEC cycle, fetch-to-fetch latency SHALL be 4 cycles: REQ, WAIT, EXEC, UPDATE.

Reset
REQ-043 Asserting rst SHALL immediately force, regardless of clk: state IDLE, ifu_req_valid=0, ifu_req_addr=0, inst=0, inst_valid=0, pc_wen=0, retired=0, halted=0, err=0, WAIT counter=0.
REQ-044 Reset asserted mid-operation, including REQ with a pending handshake, SHALL abandon the transaction.
REQ-045 After reset releases, a late ifu_rsp_valid SHALL be ignored until the next WAIT.

Verification
REQ-046 Zero-wait memory, ready=1, rsp next cycle, exu_done=1 immediately, pc=0x80000000 -> ifu_req_addr=0x80000000; pc_wen pulses every 4 cycles; retired=3 after 12 cycles from first REQ.
REQ-047 ready held 0 for 5 cycles -> ifu_req_valid=1 and ifu_req_addr unchanged for all 5 cycles; WAIT entered on the cycle ready=1.
REQ-048 TIMEOUT=4, no response -> ERROR after 4 WAIT cycles, err=1, no further requests; a response arriving on the 4th cycle instead yields EXEC.
REQ-049 inst 0x00100073 returned, exu_done=1 with halt_req=1 -> halted=1, pc_wen never asserted for it, retired unchanged.
REQ-050 rst pulsed while in WAIT, then rsp_valid=1 -> no inst latch, state IDLE then REQ, all counters 0.
REQ-051 rsp_valid with rsp_err=1, data 0xDEADBEEF -> ERROR, inst keeps its prior value, inst_valid stays 0.
